inst_fetch_queue: RTL

- Decoupling FIFO between the IF stage and the ID stage.
- Absorbs IF-to-ID handshake stalls, so IF can keep issuing SRAM-like fetch requests while ID is blocked.
- Accepts IFreg packets {ebus[15:0], inst[31:0], pc[31:0]} and presents them in order to ID.
- Discards all contents on branch redirect, exception or ertn flush.

---
 rtl/inst_fetch_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : inst_fetch_queue                                         |
// | Description : In-order decoupling FIFO between IF and ID. Absorbs ID   |
// |               stalls, drops everything on flush and blocks enqueue     |
// |               behind a faulting fetch (nonzero ebus) until flush.      |
// |               Optional macro IFQ_BYPASS_EN adds a zero-latency         |
// |               pass-through when the queue is empty.                    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module inst_fetch_queue #(
  parameter int BUS_W = 80,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] in_bus,
  output logic             in_ready,
  output logic             out_valid,
  output logic [BUS_W-1:0] out_bus,
  input  logic             out_ready,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic             ex_hold
);

  localparam logic [PTR_W:0]   c_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W+1)'(1);

  logic [BUS_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ex_hold;

  logic w_push;      // handshake completed on the input side
  logic w_pop_q;     // a stored entry is consumed by ID
  logic w_store;     // the accepted packet is written into the buffer
  logic w_ebus_nz;   // incoming packet carries an exception code

  assign w_ebus_nz = |in_bus[BUS_W-1:BUS_W-16];

  // Pop of a stored entry; kept independent of in_ready to avoid a comb loop.
  assign w_pop_q  = (r_count != '0) & out_ready;

  // Room exists when not full, or when full but the head leaves this cycle.
  assign in_ready = ~reset & ~flush & ~r_ex_hold & ((r_count < c_DEPTH) | w_pop_q);
  assign w_push   = in_valid & in_ready;

`ifdef IFQ_BYPASS_EN
  logic w_bypass;
  // Empty queue and ID ready: hand the packet straight through without storing it.
  assign w_bypass  = (r_count == '0) & in_valid & out_ready & ~flush & ~r_ex_hold & ~reset;
  assign w_store   = w_push & ~w_bypass;
  assign out_valid = (r_count != '0) | w_bypass;
  assign out_bus   = w_bypass ? in_bus : r_mem[r_rd_ptr];
`else
  // Outputs come from registered state only; minimum latency is one cycle.
  assign w_store   = w_push;
  assign out_valid = (r_count != '0);
  assign out_bus   = r_mem[r_rd_ptr];
`endif

  assign count   = r_count;
  assign ex_hold = r_ex_hold;

  // Entry storage; not reset since out_bus is don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= in_bus;
    end
  end

  // Pointers, occupancy and exception hold; flush outranks any push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ex_hold <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ex_hold <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop_q) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_store, w_pop_q})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A faulting fetch (stored or bypassed) stops younger packets entering.
      if (w_push & w_ebus_nz) begin
        r_ex_hold <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
